lv1b_trig_sched: RTL and testbench
==================================

# lv1b_trig_sched

Scheduler that merges the prescaled LV1B outputs of the per-type LV1B trigger blocks into one LV1B accept stream for the Top CDT.
- Applies a programmable hold-off between accepts and honours a downstream busy.
- Records which trigger types fired together, and keeps accept and lost-request counters that reset at each run start.
- Sits between the trigger-type LV1B blocks and the LV1B distribution logic.

## Interface
Parameters:
- N_TYPE, 8, number of trigger-type request inputs (index 0 = highest priority)
- HOLD_W, 16, width of the hold-off counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- in_live  in  1  run live; a 0->1 edge starts a run
- in_ena  in  1  global LV1B enable
- in_req  in  N_TYPE  prescaled LV1B requests, one per trigger type, 1-cycle pulses
- in_busy  in  1  downstream LV1B path cannot accept
- user_type_mask  in  N_TYPE  1 = type participates
- user_holdoff  in  HOLD_W  dead cycles after each accept
- out_lv1b  out  1  LV1B accept, 1-cycle pulse
- out_type_word  out  N_TYPE  masked requests captured with the accept
- out_type_id  out  3  index of lowest set bit of out_type_word
- out_veto  out  1  scheduler not accepting this cycle
- lv1b_cnt  out  32  accepts this run
- lost_cnt  out  32  rejected request cycles this run

## Operation
- Definitions:
  - req_m = in_req & user_type_mask.
  - A request cycle is a cycle with live & in_ena & |req_m.
- States:
  - IDLE: accepting requests.
  - ISSUE: 1 cycle; out_lv1b asserted.
  - HOLD: dead time after an accept.
- IDLE:
  - A request cycle with in_busy=0 latches req_m into out_type_word and its priority index into out_type_id, then goes to ISSUE.
  - A request cycle with in_busy=1 increments lost_cnt and stays in IDLE.
- ISSUE:
  - out_lv1b=1 and lv1b_cnt increments.
  - Loads hold_cnt=user_holdoff.
  - Goes to HOLD if user_holdoff!=0, else to IDLE.
- HOLD:
  - hold_cnt decrements each cycle; when hold_cnt==1, go to IDLE.
  - user_holdoff is sampled only in ISSUE; changes during HOLD take effect at the next accept.
- Request cycles in ISSUE or HOLD increment lost_cnt; no queuing.
- Multiple simultaneous request bits produce one accept and one lv1b_cnt increment. All bits appear in out_type_word.
- out_type_word and out_type_id hold their value until the next accept.
- out_veto = (state!=IDLE) | in_busy | !in_live | !in_ena.
- Counters:
  - Saturate at 0xFFFFFFFF.
  - Cleared on rst and on the in_live 0->1 edge. The edge is detected against a registered copy of in_live; that cycle's request is still evaluated, and counts from it land on the cleared value.
- With in_live=0 or in_ena=0, requests are ignored and not counted as lost. An ISSUE/HOLD already in progress completes normally.
- in_busy asserting during ISSUE does not cancel the pulse.

## Timing
- All outputs are registered.
- Reset values:
  - out_lv1b=0, out_type_word=0, out_type_id=0
  - lv1b_cnt=0, lost_cnt=0
  - out_veto=1, state IDLE, hold_cnt=0, registered in_live=0
- Latency: a request sampled at cycle t gives out_lv1b=1 at t+1.
- Spacing:
  - HOLD covers cycles t+2 .. t+1+H; the next request can be sampled at t+2+H.
  - Minimum spacing between out_lv1b pulses is H+2 cycles; H=0 gives 2.
- lv1b_cnt updates coincide with out_lv1b; lost_cnt updates one cycle after the rejected request.
- rst mid-HOLD returns to IDLE next cycle, clears counters and drops out_lv1b.

## Test plan
- Single accept:
  - Stimulus: mask=0xFF, holdoff=3, in_req=0x04 at cycle 10.
  - Required: out_lv1b at 11 with type_word=0x04, type_id=2, lv1b_cnt=1.
- Coincidence and masking:
  - Stimulus: mask=0xF0, in_req=0x5A.
  - Required: type_word=0x50, type_id=4, one accept.
  - Stimulus: in_req=0x0F.
  - Required: no accept, lost_cnt unchanged.
- Hold-off:
  - Stimulus: holdoff=3, requests every cycle for 20 cycles starting at cycle 0.
  - Required: accepts at 1, 6, 11, 16; lv1b_cnt=4, lost_cnt=16.
  - Stimulus: holdoff=0, same requests.
  - Required: accepts every 2 cycles, lv1b_cnt=10, lost_cnt=10.
- Busy:
  - Stimulus: in_busy=1 for cycles 5–9, requests at 6 and 8, then a request at 10.
  - Required: lost_cnt=2, then one accept at 11.
- Run boundary:
  - Stimulus: lv1b_cnt=7, lost_cnt=3, then in_live 0->1 with a request in the same cycle.
  - Required: lv1b_cnt=1, lost_cnt=0 after the pulse.
  - Stimulus: requests with in_live=0.
  - Required: no accepts, no lost counts.
- Reset mid-HOLD:
  - Stimulus: holdoff=100, rst at 20 cycles into HOLD.
  - Required: IDLE next cycle, counters 0, a request 2 cycles after rst accepted at the following cycle.

Source files
------------

// File: rtl/lv1b_trig_sched.sv
// lv1b_trig_sched: merges the per-type prescaled LV1B requests into a single
// LV1B accept stream with programmable hold-off, downstream busy handling,
// coincidence capture and per-run accept / lost-request counters.
//
// state  | meaning
// -------+----------------------------------------------
// IDLE   | accepting requests
// ISSUE  | one cycle, out_lv1b asserted, hold-off loaded
// HOLD   | dead time after an accept, hold_q counts down
module lv1b_trig_sched #(
  parameter int N_TYPE = 8,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_live,
  input  logic              in_ena,
  input  logic [N_TYPE-1:0] in_req,
  input  logic              in_busy,
  input  logic [N_TYPE-1:0] user_type_mask,
  input  logic [HOLD_W-1:0] user_holdoff,
  output logic              out_lv1b,
  output logic [N_TYPE-1:0] out_type_word,
  output logic [2:0]        out_type_id,
  output logic              out_veto,
  output logic [31:0]       lv1b_cnt,
  output logic [31:0]       lost_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              live_q;
  logic              lv1b_q, lv1b_d;
  logic [N_TYPE-1:0] word_q, word_d;
  logic [2:0]        id_q, id_d;
  logic              veto_q, veto_d;
  logic [31:0]       lv1b_cnt_q, lv1b_cnt_d;
  logic [31:0]       lost_cnt_q, lost_cnt_d;

  logic [N_TYPE-1:0] req_m;
  logic              req_cycle;
  logic              run_start;
  logic              accept;
  logic              lost;
  logic [2:0]        prio_id;
  logic [31:0]       lv1b_base;
  logic [31:0]       lost_base;

  assign req_m     = in_req & user_type_mask;
  assign req_cycle = in_live & in_ena & (|req_m);
  assign run_start = in_live & ~live_q;
  assign accept    = (state_q == S_IDLE) & req_cycle & ~in_busy;
  // Anything that is a request cycle but not taken is lost: busy in IDLE,
  // or any request arriving during ISSUE/HOLD (no queuing).
  assign lost      = req_cycle & ~accept;

  // Lowest set bit of the masked requests is the highest-priority type.
  always_comb begin
    prio_id = 3'd0;
    for (int i = N_TYPE - 1; i >= 0; i--) begin
      if (req_m[i]) prio_id = 3'(i);
    end
  end

  // Scheduler FSM next state and hold-off down-counter.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        hold_d  = user_holdoff;
        state_d = (user_holdoff != '0) ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        hold_d = hold_q - 1'b1;
        if (hold_q <= HOLD_W'(1)) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output pulse, coincidence capture, veto and saturating run counters.
  // The run-start clear is applied before the increment so a request in the
  // same cycle as the in_live rising edge lands on the cleared value.
  always_comb begin
    lv1b_d    = accept;
    word_d    = accept ? req_m : word_q;
    id_d      = accept ? prio_id : id_q;
    veto_d    = (state_d != S_IDLE) | in_busy | ~in_live | ~in_ena;
    lv1b_base = run_start ? 32'd0 : lv1b_cnt_q;
    lost_base = run_start ? 32'd0 : lost_cnt_q;
    lv1b_cnt_d = (accept && (lv1b_base != 32'hFFFF_FFFF)) ? lv1b_base + 32'd1 : lv1b_base;
    lost_cnt_d = (lost && (lost_base != 32'hFFFF_FFFF)) ? lost_base + 32'd1 : lost_base;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      live_q     <= 1'b0;
      lv1b_q     <= 1'b0;
      word_q     <= '0;
      id_q       <= 3'd0;
      veto_q     <= 1'b1;
      lv1b_cnt_q <= 32'd0;
      lost_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      live_q     <= in_live;
      lv1b_q     <= lv1b_d;
      word_q     <= word_d;
      id_q       <= id_d;
      veto_q     <= veto_d;
      lv1b_cnt_q <= lv1b_cnt_d;
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign out_lv1b      = lv1b_q;
  assign out_type_word = word_q;
  assign out_type_id   = id_q;
  assign out_veto      = veto_q;
  assign lv1b_cnt      = lv1b_cnt_q;
  assign lost_cnt      = lost_cnt_q;

endmodule

// File: tb/tb_lv1b_trig_sched.sv
// Testbench for lv1b_trig_sched: expected accepts are queued when stimulus is
// driven and popped by a monitor whenever out_lv1b fires.
module tb_lv1b_trig_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_live;
  logic        in_ena;
  logic [7:0]  in_req;
  logic        in_busy;
  logic [7:0]  user_type_mask;
  logic [15:0] user_holdoff;
  logic        out_lv1b;
  logic [7:0]  out_type_word;
  logic [2:0]  out_type_id;
  logic        out_veto;
  logic [31:0] lv1b_cnt;
  logic [31:0] lost_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [7:0] word;
    logic [2:0] id;
  } exp_t;

  exp_t sbq[$];

  lv1b_trig_sched #(.N_TYPE(8), .HOLD_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_live        (in_live),
    .in_ena         (in_ena),
    .in_req         (in_req),
    .in_busy        (in_busy),
    .user_type_mask (user_type_mask),
    .user_holdoff   (user_holdoff),
    .out_lv1b       (out_lv1b),
    .out_type_word  (out_type_word),
    .out_type_id    (out_type_id),
    .out_veto       (out_veto),
    .lv1b_cnt       (lv1b_cnt),
    .lost_cnt       (lost_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accept pulse must match the head of the scoreboard.
  exp_t mon_e;
  always @(negedge clk) begin
    if (out_lv1b === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_lv1b cyc=%0d got=1 want=0 word=%h", cyc, out_type_word);
      end else begin
        mon_e = sbq.pop_front();
        if (cyc !== mon_e.cyc || out_type_word !== mon_e.word || out_type_id !== mon_e.id) begin
          failures++;
          $display("FAIL lv1b_accept got cyc=%0d word=%h id=%0d want cyc=%0d word=%h id=%0d",
                   cyc, out_type_word, out_type_id, mon_e.cyc, mon_e.word, mon_e.id);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int c, input logic [7:0] w, input logic [2:0] id);
    exp_t e;
    e.cyc  = c;
    e.word = w;
    e.id   = id;
    sbq.push_back(e);
  endtask

  task automatic pulse_req(input logic [7:0] r);
    in_req = r;
    @(negedge clk);
    in_req = 8'h00;
  endtask

  task automatic new_run();
    in_live = 1'b0;
    tick(2);
    in_live = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    in_live        = 1'b0;
    in_ena         = 1'b0;
    in_req         = 8'h00;
    in_busy        = 1'b0;
    user_type_mask = 8'hFF;
    user_holdoff   = 16'd3;
    tick(3);
    checks++;
    if (out_lv1b !== 1'b0 || out_type_word !== 8'h00 || out_type_id !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs got lv1b=%b word=%h id=%0d want 0 00 0", out_lv1b, out_type_word, out_type_id);
    end
    checks++;
    if (lv1b_cnt !== 32'd0 || lost_cnt !== 32'd0 || out_veto !== 1'b1) begin
      failures++;
      $display("FAIL reset_counters got lv1b_cnt=%0d lost_cnt=%0d veto=%b want 0 0 1", lv1b_cnt, lost_cnt, out_veto);
    end
    rst     = 1'b0;
    in_ena  = 1'b1;
    in_live = 1'b1;
    tick(3);
    checks++;
    if (out_veto !== 1'b0) begin
      failures++;
      $display("FAIL idle_veto got=%b want=0", out_veto);
    end
  endtask

  task automatic test_single();
    new_run();
    user_holdoff = 16'd3;
    push_exp(cyc + 1, 8'h04, 3'd2);
    pulse_req(8'h04);
    checks++;
    if (lv1b_cnt !== 32'd1) begin
      failures++;
      $display("FAIL single_cnt got=%0d want=1", lv1b_cnt);
    end
    tick(2);
    checks++;
    if (out_veto !== 1'b1) begin
      failures++;
      $display("FAIL hold_veto got=%b want=1", out_veto);
    end
    tick(4);
    checks++;
    if (out_type_word !== 8'h04 || out_type_id !== 3'd2) begin
      failures++;
      $display("FAIL single_hold_word got word=%h id=%0d want 04 2", out_type_word, out_type_id);
    end
  endtask

  task automatic test_coincidence();
    new_run();
    user_type_mask = 8'hF0;
    push_exp(cyc + 1, 8'h50, 3'd4);
    pulse_req(8'h5A);
    tick(5);
    checks++;
    if (lv1b_cnt !== 32'd1) begin
      failures++;
      $display("FAIL coinc_cnt got=%0d want=1", lv1b_cnt);
    end
    pulse_req(8'h0F);
    tick(3);
    checks++;
    if (lv1b_cnt !== 32'd1 || lost_cnt !== 32'd0) begin
      failures++;
      $display("FAIL masked_req got lv1b_cnt=%0d lost_cnt=%0d want 1 0", lv1b_cnt, lost_cnt);
    end
    user_type_mask = 8'hFF;
  endtask

  task automatic test_holdoff(input int h);
    int n_acc;
    new_run();
    user_holdoff = 16'(h);
    n_acc = 0;
    for (int k = 0; k < 20; k++) begin
      in_req = 8'h01;
      if (k % (h + 2) == 0) begin
        push_exp(cyc + 1, 8'h01, 3'd0);
        n_acc++;
      end
      @(negedge clk);
    end
    in_req = 8'h00;
    tick(h + 3);
    checks++;
    if (lv1b_cnt !== 32'(n_acc) || lost_cnt !== 32'(20 - n_acc)) begin
      failures++;
      $display("FAIL holdoff_%0d got lv1b_cnt=%0d lost_cnt=%0d want %0d %0d",
               h, lv1b_cnt, lost_cnt, n_acc, 20 - n_acc);
    end
  endtask

  task automatic test_busy();
    new_run();
    user_holdoff = 16'd3;
    for (int r = 0; r < 16; r++) begin
      if (r == 7) begin
        checks++;
        if (out_veto !== 1'b1 || lost_cnt !== 32'd1) begin
          failures++;
          $display("FAIL busy_mid got veto=%b lost_cnt=%0d want 1 1", out_veto, lost_cnt);
        end
      end
      in_busy = (r >= 5 && r <= 9);
      in_req  = (r == 6 || r == 8 || r == 10) ? 8'h02 : 8'h00;
      if (r == 10) push_exp(cyc + 1, 8'h02, 3'd1);
      @(negedge clk);
    end
    in_req  = 8'h00;
    in_busy = 1'b0;
    tick(4);
    checks++;
    if (lost_cnt !== 32'd2 || lv1b_cnt !== 32'd1) begin
      failures++;
      $display("FAIL busy_counts got lost_cnt=%0d lv1b_cnt=%0d want 2 1", lost_cnt, lv1b_cnt);
    end
  endtask

  task automatic test_run_boundary();
    new_run();
    user_holdoff = 16'd0;
    for (int k = 0; k < 7; k++) begin
      push_exp(cyc + 1, 8'h02, 3'd1);
      pulse_req(8'h02);
      tick(2);
    end
    in_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pulse_req(8'h01);
      tick(1);
    end
    in_busy = 1'b0;
    tick(2);
    checks++;
    if (lv1b_cnt !== 32'd7 || lost_cnt !== 32'd3) begin
      failures++;
      $display("FAIL preload_counts got lv1b_cnt=%0d lost_cnt=%0d want 7 3", lv1b_cnt, lost_cnt);
    end
    in_live = 1'b0;
    tick(2);
    in_live = 1'b1;
    in_req  = 8'h80;
    push_exp(cyc + 1, 8'h80, 3'd7);
    @(negedge clk);
    in_req = 8'h00;
    checks++;
    if (lv1b_cnt !== 32'd1 || lost_cnt !== 32'd0) begin
      failures++;
      $display("FAIL run_start got lv1b_cnt=%0d lost_cnt=%0d want 1 0", lv1b_cnt, lost_cnt);
    end
    tick(3);
    in_ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pulse_req(8'h03);
      tick(1);
    end
    in_ena = 1'b1;
    tick(2);
    checks++;
    if (lv1b_cnt !== 32'd1 || lost_cnt !== 32'd0) begin
      failures++;
      $display("FAIL ena_off got lv1b_cnt=%0d lost_cnt=%0d want 1 0", lv1b_cnt, lost_cnt);
    end
    in_live = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pulse_req(8'h0C);
      tick(1);
    end
    tick(2);
    checks++;
    if (lv1b_cnt !== 32'd1 || lost_cnt !== 32'd0) begin
      failures++;
      $display("FAIL live_off got lv1b_cnt=%0d lost_cnt=%0d want 1 0", lv1b_cnt, lost_cnt);
    end
    in_live = 1'b1;
  endtask

  task automatic test_reset_hold();
    new_run();
    user_holdoff = 16'd100;
    push_exp(cyc + 1, 8'h08, 3'd3);
    pulse_req(8'h08);
    tick(20);
    checks++;
    if (out_veto !== 1'b1 || lv1b_cnt !== 32'd1) begin
      failures++;
      $display("FAIL in_hold got veto=%b lv1b_cnt=%0d want 1 1", out_veto, lv1b_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_lv1b !== 1'b0 || lv1b_cnt !== 32'd0 || lost_cnt !== 32'd0 || out_type_word !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_hold got lv1b=%b lv1b_cnt=%0d lost_cnt=%0d word=%h want 0 0 0 00",
               out_lv1b, lv1b_cnt, lost_cnt, out_type_word);
    end
    tick(1);
    push_exp(cyc + 1, 8'h10, 3'd4);
    pulse_req(8'h10);
    checks++;
    if (lv1b_cnt !== 32'd1) begin
      failures++;
      $display("FAIL post_rst_accept got lv1b_cnt=%0d want 1", lv1b_cnt);
    end
    tick(3);
    user_holdoff = 16'd3;
  endtask

  initial begin
    test_reset();
    test_single();
    test_coincidence();
    test_holdoff(3);
    test_holdoff(0);
    test_holdoff(1);
    test_busy();
    test_run_boundary();
    test_reset_hold();
    tick(5);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL missing_accepts got pending=%0d want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
